// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencer. Pulses pll_rst_o, waits for a stable
// synchronized lock, then releases sys_rst_o. Retries the PLL on lock timeout
// and re-sequences on lock loss. Clocked by the free-running reference clock.
// Ports:
//   clk_i          reference clock (same source as PLL CLKIN1)
//   rst_i          async active-high reset
//   pll_locked_i   PLL LOCKED, asynchronous to clk_i
//   pll_rst_o      PLL RST drive, active-high
//   sys_rst_o      system reset for PLL-clocked logic, active-high
//   ready_o        high only while running
//   retry_cnt_o    lock-timeout count, saturating at 255
//   lock_lost_o    one-cycle pulse when lock drops while running
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic [7:0] retry_cnt_o,
    output logic       lock_lost_o
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                           PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_PLL_RST = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_STABLE  = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic          r_sync;
    logic          r_lock_s;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_retry;
    logic          r_pll_rst;
    logic          r_sys_rst;
    logic          r_ready;
    logic          r_lock_lost;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_retry_inc;
    logic          w_lock_lost;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync   <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync   <= pll_locked_i;
            r_lock_s <= r_sync;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_retry_inc = 1'b0;
        w_lock_lost = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == PR_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                // Lock takes priority over a timeout on the same cycle.
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == ST_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_lock_lost = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same
    // edge as the state register while staying registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_retry     <= 8'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_rst   <= (w_state_nxt == S_PLL_RST);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_lock_lost <= w_lock_lost;
            if (w_retry_inc && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign sys_rst_o   = r_sys_rst;
    assign ready_o     = r_ready;
    assign retry_cnt_o = r_retry;
    assign lock_lost_o = r_lock_lost;

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer sitting on the consumer side of the Artix-7 PLL wrapper. It drives the PLL `RST` input, watches the PLL `LOCKED` output and releases the design's system reset only after lock has been stable for a programmable time. It retries the PLL on a lock timeout and re-sequences automatically on lock loss. It runs on the free-running reference clock, never on a PLL output.

## Interface
- `PLL_RST_CYCLES`, default 16 — cycles `pll_rst_o` is held high per PLL reset pulse; ≥1.
- `LOCK_TIMEOUT`, default 65536 — cycles allowed in WAIT_LOCK before a retry; ≥1.
- `STABLE_CYCLES`, default 1024 — cycles synchronized lock must stay high before system reset release; ≥1.
- Internal counter width: clog2 of the largest of the three parameters, plus 1.

- `clk_i` input 1 — reference clock, same source as the PLL `CLKIN1`.
- `rst_i` input 1 — asynchronous, active-high reset.
- `pll_locked_i` input 1 — PLL `LOCKED`; asynchronous to `clk_i`.
- `pll_rst_o` output 1 — drives PLL `RST`; active-high.
- `sys_rst_o` output 1 — active-high system reset for logic clocked by PLL outputs.
- `ready_o` output 1 — high only in RUN.
- `retry_cnt_o` output 8 — number of lock timeouts; saturates at 255.
- `lock_lost_o` output 1 — one-cycle pulse on lock loss while in RUN.

## Operation
- `pll_locked_i` passes through a 2-flop synchronizer (flops reset to 0) to give `lock_s`. All decisions use `lock_s`.
- State machine: PLL_RST, WAIT_LOCK, STABLE, RUN. Reset state is PLL_RST with the counter at 0.
- **PLL_RST**
  - `pll_rst_o`=1, `sys_rst_o`=1, `ready_o`=0.
  - Counter increments each cycle. At count == PLL_RST_CYCLES-1: go to WAIT_LOCK and clear the counter.
- **WAIT_LOCK**
  - `pll_rst_o`=0, `sys_rst_o`=1.
  - If `lock_s`=1: go to STABLE and clear the counter.
  - Else at count == LOCK_TIMEOUT-1: go to PLL_RST, clear the counter, and increment `retry_cnt_o` (saturating).
  - If lock arrives on the timeout cycle, lock wins.
- **STABLE**
  - `pll_rst_o`=0, `sys_rst_o`=1.
  - If `lock_s`=0: go to PLL_RST and clear the counter. No retry increment, no `lock_lost_o`.
  - Else at count == STABLE_CYCLES-1: go to RUN.
- **RUN**
  - `pll_rst_o`=0, `sys_rst_o`=0, `ready_o`=1.
  - If `lock_s`=0: go to PLL_RST and pulse `lock_lost_o` for exactly one cycle.
- `retry_cnt_o` is cleared only by `rst_i`. Lock loss does not modify it.

## Timing
- All outputs are registered and change on the same edge as the state register. There are no combinational paths from inputs to outputs.
- Reset values while `rst_i`=1 (applied asynchronously):
  - `pll_rst_o`=1, `sys_rst_o`=1
  - `ready_o`=0, `retry_cnt_o`=0, `lock_lost_o`=0
  - state PLL_RST, synchronizer flops 0
- After `rst_i` deasserts, `pll_rst_o` stays high for exactly PLL_RST_CYCLES rising edges.
- A `pll_locked_i` rise is visible in `lock_s` after 2 edges. The WAIT_LOCK→STABLE transition happens on the 3rd edge.
- `sys_rst_o` falls and `ready_o` rises STABLE_CYCLES edges after entry to STABLE.
- Lock-loss response:
  - Edge 3 after `pll_locked_i` falls: `sys_rst_o`=1, `pll_rst_o`=1, `ready_o`=0 and `lock_lost_o`=1, all on the same edge.
  - `lock_lost_o` returns to 0 on the next edge.
- Retry period with no lock: PLL_RST_CYCLES + LOCK_TIMEOUT cycles per attempt.
- A `pll_locked_i` pulse shorter than one clock may be missed. That is accepted.
- If `rst_i` is asserted mid-sequence, it overrides everything immediately. The sequence restarts from PLL_RST on release.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.

- **Nominal lock:** release `rst_i`, raise `pll_locked_i` 10 cycles after `pll_rst_o` falls → `pll_rst_o` high 4 cycles; `sys_rst_o` falls and `ready_o` rises 3+8=11 cycles after the lock rise; `retry_cnt_o`=0.
- **No lock:** hold `pll_locked_i`=0 → `pll_rst_o` re-pulses every 36 cycles; `retry_cnt_o` reads 1, 2, 3 after the first, second and third timeouts; `sys_rst_o` stays 1.
- **Lock glitch in STABLE:** drop `pll_locked_i` for 3 cycles at cycle 4 of STABLE → return to PLL_RST; `sys_rst_o` never falls; `lock_lost_o` stays 0; `retry_cnt_o` unchanged; a later steady lock completes normally.
- **Loss in RUN:** drop `pll_locked_i` → exactly one `lock_lost_o` cycle on edge 3, with `sys_rst_o`=1 and `pll_rst_o`=1 on that edge; relock then re-releases `sys_rst_o` after the full sequence.
- **Async reset mid-WAIT_LOCK:** assert `rst_i` between clock edges → all outputs take reset values before the next edge; `retry_cnt_o`=0 after release.
- **Saturation:** LOCK_TIMEOUT=1, PLL_RST_CYCLES=1, no lock for 300 attempts → `retry_cnt_o` reaches 255 and holds.
